scancode_decoder: RTL
=====================

# scancode_decoder

Downstream consumer of the PS/2 byte receiver: takes each validated 8-bit frame (`word` qualified by a one-`sysclk` `done` pulse) and folds PS/2 Set 2 prefix bytes (E0 extended, F0 break) into single key events. Events are buffered in a small FIFO and offered on a valid/ready port to the keyboard-event consumer. Malformed prefix sequences, reserved error bytes and FIFO overflow are flagged on a one-cycle error strobe.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `sysclk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `word`  in  8  received byte; sampled only when `done`=1.
- `done`  in  1  one-cycle strobe: `word` valid this cycle.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_ready`  in  1  consumer accepts head entry when `ev_valid`&&`ev_ready`.
- `ev_code`  out  8  head entry key code (final byte of sequence).
- `ev_ext`  out  1  head entry had E0 prefix.
- `ev_brk`  out  1  head entry had F0 prefix (key release).
- `err`  out  1  one-cycle pulse on any protocol error or overflow.

## Operation
- Registered prefix flags `ext_r`, `brk_r`; state `S_IDLE` or `S_PAUSE` (macro only).
- In `S_IDLE`, on `done`:
  - `word`=E0: if `brk_r`=1 → `err`, clear both flags (F0 E0 illegal). If `ext_r`=1 already → `err`, flags unchanged. Else set `ext_r`.
  - `word`=F0: if `brk_r`=1 → `err`, flags unchanged. Else set `brk_r`.
  - `word`=00 or FF (keyboard error/overrun): byte dropped, `err`, flags cleared.
  - `word`=E1: see Configuration.
  - any other byte: push {`brk_r`,`ext_r`,`word`}, clear both flags.
- FIFO: `DEPTH` entries × 10 bits, read/write pointers with one extra wrap bit; full = pointers equal except MSB.
  - Push when full and no pop same cycle: entry dropped, `err`; FIFO contents unchanged.
  - Push and pop same cycle when full: both succeed, count unchanged.
  - Push and pop same cycle when empty: impossible (pop requires `ev_valid`); push lands, `ev_valid` next cycle.
  - `ev_code/ev_ext/ev_brk` show head entry; undefined-but-stable (zero after reset) when empty.
- `done` held high multiple cycles is not legal input; each high cycle is treated as a separate byte.

## Timing
- Reset values: `ev_valid`=0, `ev_code`=0, `ev_ext`=0, `ev_brk`=0, `err`=0; flags cleared, state `S_IDLE`, FIFO empty, pause counter 0.
- Reset mid-sequence discards pending prefixes and all FIFO entries.
- Latency: `done` with terminal byte at cycle N → `ev_valid`=1 at N+1 (if FIFO was empty).
- Pop at cycle N → next entry (or `ev_valid`=0) visible N+1.
- `err` asserted at cycle N+1 for a `done` error at N; exactly one cycle.
- Throughput: one byte per `sysclk`; one pop per `sysclk`.

## Configuration
- `SCANCODE_PAUSE_EN` defined: E1 in `S_IDLE` with both flags clear enters `S_PAUSE`, index 0; each subsequent byte is compared with expected sequence 14 77 E1 F0 14 F0 77. Match advances index; after 7th match push {brk=0, ext=0, code=E1} once and return to `S_IDLE`. Mismatch → `err`, mismatching byte discarded, return to `S_IDLE`. E1 with a prefix pending → `err`, flags cleared.
- Not defined: no `S_PAUSE`; E1 is an ordinary byte (pushed with current flags), so Pause produces raw events E1,14,77,E1,{brk}14,{brk}77.

## Test plan
- Bytes 1C → one event code=1C, ext=0, brk=0; `ev_valid` one cycle after `done`.
- E0 F0 74 → one event code=74, ext=1, brk=1; no event for prefixes; `err` never asserted.
- F0 E0 then 1C → `err` pulse on E0; then event code=1C ext=0 brk=0.
- `ev_ready`=0, DEPTH=4, send 5 codes 15,16,17,18,19 → `err` on 5th; drain yields 15,16,17,18; then simultaneous push/pop while full keeps count at 4.
- With `SCANCODE_PAUSE_EN`: E1 14 77 E1 F0 14 F0 77 → single event code=E1 ext=0 brk=0; E1 14 33 → `err`, no event. Without macro: same 8 bytes → 6 events as listed above.
- Reset asserted after E0 F0 with 2 entries queued → `ev_valid`=0 next cycle; following 1C yields ext=0 brk=0.

Source files
------------

// File: rtl/scancode_decoder.sv
// PS/2 Set 2 scancode folder: merges E0/F0 prefixes into key events queued in a small FIFO.
// Optional Pause-sequence collapsing is enabled by defining SCANCODE_PAUSE_EN.
module scancode_decoder #(
    parameter int DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] word,
    input  logic       done,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       err
);
    localparam int AW = $clog2(DEPTH);

    logic       ext_reg, ext_next;
    logic       brk_reg, brk_next;
    logic       push_req;
    logic       proto_err;
    logic [9:0] push_data;

    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [9:0]  mem_reg [DEPTH];
    logic        err_reg;
    logic        full, empty, pop, do_push, overflow;

`ifdef SCANCODE_PAUSE_EN
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_PAUSE = 1'b1;

    logic [0:0] state_reg, state_next;
    logic [2:0] pause_idx_reg, pause_idx_next;
    logic [7:0] pause_expect;

    // Remainder of the make+break Pause sequence after the leading E1.
    always_comb begin
        case (pause_idx_reg)
            3'd0:    pause_expect = 8'h14;
            3'd1:    pause_expect = 8'h77;
            3'd2:    pause_expect = 8'hE1;
            3'd3:    pause_expect = 8'hF0;
            3'd4:    pause_expect = 8'h14;
            3'd5:    pause_expect = 8'hF0;
            default: pause_expect = 8'h77;
        endcase
    end
`endif

    always_comb begin
        ext_next  = ext_reg;
        brk_next  = brk_reg;
        push_req  = 1'b0;
        proto_err = 1'b0;
        push_data = {brk_reg, ext_reg, word};
`ifdef SCANCODE_PAUSE_EN
        state_next     = state_reg;
        pause_idx_next = pause_idx_reg;
`endif
        if (done) begin
`ifdef SCANCODE_PAUSE_EN
            if (state_reg == S_PAUSE) begin
                if (word == pause_expect) begin
                    if (pause_idx_reg == 3'd6) begin
                        push_req       = 1'b1;
                        push_data      = {2'b00, 8'hE1};
                        state_next     = S_IDLE;
                        pause_idx_next = 3'd0;
                    end else begin
                        pause_idx_next = pause_idx_reg + 3'd1;
                    end
                end else begin
                    proto_err      = 1'b1;
                    state_next     = S_IDLE;
                    pause_idx_next = 3'd0;
                end
            end else begin
`endif
            case (word)
                8'hE0: begin
                    if (brk_reg) begin
                        proto_err = 1'b1;
                        ext_next  = 1'b0;
                        brk_next  = 1'b0;
                    end else if (ext_reg) begin
                        proto_err = 1'b1;
                    end else begin
                        ext_next = 1'b1;
                    end
                end
                8'hF0: begin
                    if (brk_reg) proto_err = 1'b1;
                    else         brk_next  = 1'b1;
                end
                8'h00, 8'hFF: begin
                    proto_err = 1'b1;
                    ext_next  = 1'b0;
                    brk_next  = 1'b0;
                end
`ifdef SCANCODE_PAUSE_EN
                8'hE1: begin
                    if (ext_reg || brk_reg) begin
                        proto_err = 1'b1;
                        ext_next  = 1'b0;
                        brk_next  = 1'b0;
                    end else begin
                        state_next     = S_PAUSE;
                        pause_idx_next = 3'd0;
                    end
                end
`endif
                default: begin
                    push_req = 1'b1;
                    ext_next = 1'b0;
                    brk_next = 1'b0;
                end
            endcase
`ifdef SCANCODE_PAUSE_EN
            end
`endif
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop      = !empty && ev_ready;
    assign do_push  = push_req && (!full || pop);
    assign overflow = push_req && full && !pop;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            ext_reg    <= 1'b0;
            brk_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            ext_reg <= ext_next;
            brk_reg <= brk_next;
            err_reg <= proto_err || overflow;
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

`ifdef SCANCODE_PAUSE_EN
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            pause_idx_reg <= 3'd0;
        end else begin
            state_reg     <= state_next;
            pause_idx_reg <= pause_idx_next;
        end
    end
`endif

    // Entries are cleared on reset so the head reads as zero when empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge sysclk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign ev_valid                 = !empty;
    assign {ev_brk, ev_ext, ev_code} = mem_reg[rd_ptr_reg[AW-1:0]];
    assign err                      = err_reg;

endmodule
